// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice, LSB-first over WIDTH cycles.
// Optional subtract mode is enabled with `define SERIAL_ADD_CTRL_SUB_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] opa, opb, acc;
    logic [CW-1:0]    count;
    logic             carry;

    logic             load, step, finish;
    logic [WIDTH-1:0] opb_init;
    logic             carry_init;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] acc_next;

    // Subtraction is a + ~b + 1, so only the operand/carry load differs.
    always_comb begin
`ifdef SERIAL_ADD_CTRL_SUB_EN
        opb_init   = sub ? ~b : b;
        carry_init = sub ? 1'b1 : cin;
`else
        opb_init   = b;
        carry_init = cin;
`endif
    end

    always_comb begin
        bit_s    = opa[0] ^ opb[0] ^ carry;
        bit_c    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        acc_next = {bit_s, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            count <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            opa   <= a;
            opb   <= opb_init;
            acc   <= '0;
            count <= '0;
            carry <= carry_init;
        end else if (step) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            acc   <= acc_next;
            carry <= bit_c;
            // Clear rather than increment on the last bit so count never wraps.
            if (finish) begin
                count <= '0;
                sum   <= acc_next;
                cout  <= bit_c;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed test-plan steps plus random
// operations checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub_in;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_CTRL_SUB_EN
        .sub   (sub_in),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Reference: {cout, sum} from plain arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        longint unsigned t;
        logic [W-1:0]    d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        t = longint'(x) + longint'(y) + longint'(ci);
        return t[W:0];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge (edge 0) and scrambles the inputs afterwards.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s);
        a = x; b = y; cin = ci; sub_in = s; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_in = 1'($urandom);
        check_bit("busy_edge0", busy, 1'b1);
        check_bit("done_edge0", done, 1'b0);
        check_word("sum_held_edge0", sum, prev_sum);
    endtask

    // Walks edges 1..W; optionally pulses start on cycles 2 and 5 (must be ignored).
    task automatic follow(input logic [W:0] exp, input logic pulse);
        for (int k = 1; k <= int'(W); k++) begin
            start = pulse && (k == 2 || k == 5);
            if (pulse) begin
                a = W'($urandom); b = W'($urandom);
            end
            tick();
            if (k < int'(W)) begin
                check_bit("busy_run", busy, 1'b1);
                check_bit("done_run", done, 1'b0);
                check_word("sum_held_run", sum, prev_sum);
                check_bit("cout_held_run", cout, prev_cout);
            end else begin
                check_bit("busy_done", busy, 1'b0);
                check_bit("done_pulse", done, 1'b1);
                check_word("sum_result", sum, exp[W-1:0]);
                check_bit("cout_result", cout, exp[W]);
                prev_sum  = exp[W-1:0];
                prev_cout = exp[W];
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_check();
        tick();
        check_bit("busy_idle", busy, 1'b0);
        check_bit("done_idle", done, 1'b0);
        check_word("sum_idle", sum, prev_sum);
        check_bit("cout_idle", cout, prev_cout);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s);
        logic [W:0] exp;
        exp = model(x, y, ci, s);
        start_op(x, y, ci, s);
        follow(exp, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic         rc, rs;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_in = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        tick();
        tick();
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_word("reset_sum", sum, '0);
        check_bit("reset_cout", cout, 1'b0);
        rst = 1'b0;
        idle_check();

        op(8'h35, 8'h4A, 1'b0, 1'b0);
        check_word("tp_35_4a", sum, 8'h7F);
        idle_check();
        op(8'hFF, 8'h01, 1'b0, 1'b0);
        idle_check();
        op(8'hFF, 8'hFF, 1'b1, 1'b0);
        idle_check();

        // Ignored starts during RUN, then back-to-back start in the DONE cycle.
        start_op(8'h0F, 8'h01, 1'b0, 1'b0);
        follow(model(8'h0F, 8'h01, 1'b0, 1'b0), 1'b1);
        check_word("tp_0f_01", sum, 8'h10);
        op(8'h80, 8'h80, 1'b0, 1'b0);
        check_bit("tp_80_80_cout", cout, 1'b1);
        idle_check();

        // Reset while RUN bit 4 is being processed.
        start_op(8'hAA, 8'h55, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_word("abort_sum", sum, '0);
        check_bit("abort_cout", cout, 1'b0);
        rst = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            tick();
            check_bit("abort_no_done", done, 1'b0);
            check_bit("abort_no_busy", busy, 1'b0);
        end

`ifdef SERIAL_ADD_CTRL_SUB_EN
        op(8'h10, 8'h01, 1'b0, 1'b1);
        check_word("tp_sub_10_01", sum, 8'h0F);
        idle_check();
        op(8'h01, 8'h02, 1'b1, 1'b1);
        check_word("tp_sub_01_02", sum, 8'hFF);
        idle_check();
`endif

        for (int n = 0; n < 24; n++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_CTRL_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            op(rx, ry, rc, rs);
            if ($urandom_range(1, 0) == 1) idle_check();
        end
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in on a start pulse, then sequences one full-adder cell LSB-first over WIDTH cycles with a registered carry, and presents the sum and carry-out with a done pulse. It sits between a requesting datapath and a single shared 1-bit full-adder slice, trading latency for area in the team's arithmetic blocks.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when not busy
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered final carry, held with sum

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift/count/carry registers=0.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. When start=1 at an edge, latch a->opa, b->opb, cin->carry, count=0, and go to RUN.
- RUN: busy=1. Each edge computes one bit: s=opa[0]^opb[0]^carry and c=majority(opa[0],opb[0],carry).
  - opa and opb shift right by 1.
  - s shifts into the MSB of the work register acc, which shifts right.
  - carry<=c and count<=count+1.
  - When count reaches WIDTH-1, the last bit is processed on that edge, sum<=final acc, cout<=final carry, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle and busy=0. Go to IDLE, or directly to RUN if start=1 that cycle. A start in DONE is accepted with the same latching as in IDLE.
- Latency: the edge that samples start is edge 0. The RUN bit edges are 1..WIDTH. done is high in the cycle following edge WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued and has no effect on the in-flight operation.
- sum and cout change only at completion and stay stable during RUN, so the previous result remains readable.
- The count register is clog2(WIDTH) bits wide and never wraps during an operation.
- Reset mid-operation: takes priority over everything. The operation is aborted with no done pulse and all outputs go to their reset values on the next edge.
- Inputs a, b and cin may change freely after the accepted start edge.

Optional Feature:
Macro SERIAL_ADD_CTRL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on an accepted start.
  - When sub=1, opb is loaded as ~b and carry is loaded as 1. cin is ignored.
  - The result is a-b mod 2^WIDTH, with cout=1 meaning no borrow.
  - When sub=0, behaviour is identical to the plain adder.
- Not defined: no sub port exists and the block is the adder only.

Test Plan:
- WIDTH=8: rst 2 cycles, then start with a=0x35, b=0x4A, cin=0 -> done pulses 9 cycles after the start edge, sum=0x7F, cout=0, busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start pulses on cycles 2 and 5 of a running 0x0F+0x01 operation -> ignored; single done with sum=0x10, cout=0, and the prior sum held until completion.
- start asserted in the DONE cycle with a=0x80, b=0x80 -> immediate RUN, no IDLE cycle; next done 9 cycles later with sum=0x00, cout=1.
- rst asserted at RUN bit 4 of 0xAA+0x55 -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows.
- With SERIAL_ADD_CTRL_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. Then sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
